// File: rtl/wb_pkg.sv
// Shared types and default sizes for the integer register-file writeback unit.
// Optional bypass outputs are enabled with the WB_BYPASS_EN macro.
package wb_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int WB_AW        = $clog2(NUM_REGS_DEF);

    typedef logic [WB_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic                valid;
        reg_addr_t           rd;
        logic [XLEN_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard for long-latency ops, with issue/hazard stalls.
// Under WB_BYPASS_EN, sources being written this cycle are not treated as hazards.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    output logic          issue_stall,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          hazard_stall,
    input  logic          rf_we,
    input  logic [AW-1:0] rf_rd_addr
);

    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic                issue_set_s;
    logic                fwd1_s;
    logic                fwd2_s;

    assign issue_stall = issue_valid && pending_r[issue_rd];
    assign issue_set_s = issue_valid && !issue_stall && (issue_rd != {AW{1'b0}});

    // Build one-hot set/clear masks for this edge.
    always_comb begin
        set_mask_s = {NUM_REGS{1'b0}};
        clr_mask_s = {NUM_REGS{1'b0}};
        if (issue_set_s) begin
            set_mask_s[issue_rd] = 1'b1;
        end else begin
            set_mask_s = {NUM_REGS{1'b0}};
        end
        if (rf_we) begin
            clr_mask_s[rf_rd_addr] = 1'b1;
        end else begin
            clr_mask_s = {NUM_REGS{1'b0}};
        end
    end

    // Pending vector; a set on the same edge as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {NUM_REGS{1'b0}};
        end else begin
            pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Sources matched by the write on the RF port this cycle can be forwarded.
    always_comb begin
        fwd1_s = 1'b0;
        fwd2_s = 1'b0;
`ifdef WB_BYPASS_EN
        if (rf_we) begin
            fwd1_s = (rf_rd_addr == rs1_addr) && (rs1_addr != {AW{1'b0}});
            fwd2_s = (rf_rd_addr == rs2_addr) && (rs2_addr != {AW{1'b0}});
        end else begin
            fwd1_s = 1'b0;
            fwd2_s = 1'b0;
        end
`endif
    end

    assign hazard_stall = ((rs1_addr != {AW{1'b0}}) && pending_r[rs1_addr] && !fwd1_s) ||
                          ((rs2_addr != {AW{1'b0}}) && pending_r[rs2_addr] && !fwd2_s);

endmodule

// File: rtl/writeback_unit.sv
// Register-file writer: merges ALU and LSU results onto the single RF write port.
// Define WB_BYPASS_EN to add the fwd_rs1/fwd_rs2 forwarding outputs.
module writeback_unit
    import wb_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_stall,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            hazard_stall,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd_addr,
    output logic [XLEN-1:0] rf_rd_data
`ifdef WB_BYPASS_EN
    ,
    output logic            fwd_rs1_valid,
    output logic [XLEN-1:0] fwd_rs1_data,
    output logic            fwd_rs2_valid,
    output logic [XLEN-1:0] fwd_rs2_data
`endif
);

    wb_req_t alu_req_s;
    wb_req_t lsu_req_s;
    wb_req_t sel_s;
    wb_req_t buf_r;
    wb_req_t port_r;
    logic    lsu_xfer_s;
    logic    sel_write_s;

    assign alu_req_s   = '{valid: alu_valid, rd: alu_rd, data: alu_data};
    assign lsu_req_s   = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};
    assign lsu_ready   = !buf_r.valid;
    assign lsu_xfer_s  = lsu_valid && !buf_r.valid;
    assign sel_write_s = sel_s.valid && (sel_s.rd != {AW{1'b0}});

    // Fixed priority: ALU, then buffered LSU entry, then the incoming LSU transfer.
    always_comb begin
        sel_s = '0;
        if (alu_valid) begin
            sel_s = alu_req_s;
        end else if (buf_r.valid) begin
            sel_s = buf_r;
        end else if (lsu_xfer_s) begin
            sel_s = lsu_req_s;
        end else begin
            sel_s = '0;
        end
    end

    // One-entry skid buffer for an LSU response that lost to the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_r <= '0;
        end else if (lsu_xfer_s && alu_valid) begin
            buf_r <= lsu_req_s;
        end else if (buf_r.valid && !alu_valid) begin
            buf_r.valid <= 1'b0;
        end else begin
            buf_r <= buf_r;
        end
    end

    // Registered RF write port; rd=0 consumes the slot without writing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_r <= '0;
        end else begin
            port_r.valid <= sel_write_s;
            if (sel_write_s) begin
                port_r.rd   <= sel_s.rd;
                port_r.data <= sel_s.data;
            end else begin
                port_r.rd   <= port_r.rd;
                port_r.data <= port_r.data;
            end
        end
    end

    assign rf_we      = port_r.valid;
    assign rf_rd_addr = port_r.rd;
    assign rf_rd_data = port_r.data;

`ifdef WB_BYPASS_EN
    assign fwd_rs1_valid = port_r.valid && (port_r.rd == rs1_addr) && (rs1_addr != {AW{1'b0}});
    assign fwd_rs2_valid = port_r.valid && (port_r.rd == rs2_addr) && (rs2_addr != {AW{1'b0}});
    assign fwd_rs1_data  = port_r.data;
    assign fwd_rs2_data  = port_r.data;
`endif

    wb_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_stall  (issue_stall),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .hazard_stall (hazard_stall),
        .rf_we        (port_r.valid),
        .rf_rd_addr   (port_r.rd)
    );

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writer side of the integer register file. It owns the single RF write port (address, data, write enable).
- Merges results from the single-cycle ALU path and the multi-cycle LSU response path into that port.
- Keeps a per-register pending scoreboard of outstanding long-latency destinations.
- Drives operand-hazard and issue stalls back to decode.

Parameters:
- XLEN, 32, data width of results and RF write data.
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- AW, $clog2(NUM_REGS), register address width (derived, not overridden).

Ports:
- clk  input  1  core clock
- rst_n  input  1  reset, asynchronous assert, active-low
- issue_valid  input  1  decode issues a long-latency (LSU load) op this cycle
- issue_rd  input  AW  destination of the issued op
- issue_stall  output  1  issue_rd is already pending (WAW); decode must hold
- rs1_addr  input  AW  decode source 1 address
- rs2_addr  input  AW  decode source 2 address
- hazard_stall  output  1  a source register is pending
- alu_valid  input  1  ALU result valid; no backpressure
- alu_rd  input  AW  ALU destination
- alu_data  input  XLEN  ALU result
- lsu_valid  input  1  LSU response valid
- lsu_ready  output  1  unit accepts LSU response
- lsu_rd  input  AW  LSU destination
- lsu_data  input  XLEN  LSU load data
- rf_we  output  1  RF write enable (registered)
- rf_rd_addr  output  AW  RF write address (registered)
- rf_rd_data  output  XLEN  RF write data (registered)

Behaviour:
- Reset (async, rst_n low): rf_we=0, rf_rd_addr=0, rf_rd_data=0, buffer empty, all pending bits 0. Outputs while in reset: lsu_ready=1, issue_stall=0, hazard_stall=0.
- LSU handshake:
  - A transfer occurs when lsu_valid and lsu_ready are both high at a rising edge.
  - lsu_ready = !buf_valid, combinational from state only.
  - A source holding lsu_valid must keep lsu_rd/lsu_data stable until accepted.
- Write selection each cycle, fixed priority:
  1. ALU, if alu_valid.
  2. Else the buffered LSU entry, if buf_valid.
  3. Else the incoming LSU transfer.
- An incoming LSU transfer that is not selected (ALU active that cycle) is captured into the 1-entry buffer.
- Latency: a result selected in cycle N appears on rf_we/rf_rd_addr/rf_rd_data in cycle N+1. The RF commits it at the edge ending N+1.
- Register 0: a selected result with rd=0 is consumed (it counts as the cycle's write) but rf_we stays 0. rf_rd_addr and rf_rd_data are don't-care in that case.
- If nothing is selected, rf_we=0 next cycle; address and data hold their previous values.
- Scoreboard:
  - pending[issue_rd] is set at the edge where issue_valid && !issue_stall && issue_rd!=0.
  - pending[a] is cleared at the edge where rf_we && rf_rd_addr==a.
  - Simultaneous set and clear of the same bit: set wins.
  - pending[0] is never set.
- issue_stall = issue_valid && pending[issue_rd] (combinational).
- hazard_stall = (rs1_addr!=0 && pending[rs1_addr]) || (rs2_addr!=0 && pending[rs2_addr]).
- The stall holds through the cycle in which the write sits on the RF port, because the RF is read-before-write.
- ALU writes neither set nor clear pending, except through the common rf_we clear. WAW between ALU and LSU is prevented by decode honouring issue_stall.
- Reset mid-operation: the buffer entry, the in-flight registered write and all pending bits are discarded. No RF write occurs after rst_n deasserts until a new result arrives.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds outputs fwd_rs1_valid, fwd_rs1_data, fwd_rs2_valid, fwd_rs2_data.
  - fwd_rsX_valid = rf_we && rf_rd_addr==rsX_addr && rsX_addr!=0; fwd_rsX_data = rf_rd_data.
  - hazard_stall excludes any source whose fwd_rsX_valid is 1, which removes the one-cycle read-before-write bubble.
- Undefined: these ports do not exist; hazard_stall is as described above.

Decomposition:
- Package wb_pkg holds:
  - XLEN_DEF and NUM_REGS_DEF constants.
  - typedef reg_addr_t (AW-bit logic).
  - typedef wb_req_t, a struct {logic valid; reg_addr_t rd; logic [XLEN-1:0] data;} used for the ALU input, the LSU input, the buffer and the registered port.
- One sub-module, wb_scoreboard: pending bit vector with set/clear logic plus issue_stall/hazard_stall generation.
- Arbitration and the buffer stay in the top module.

Test Plan:
- After reset, alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle -> next cycle rf_we=1, rf_rd_addr=5, rf_rd_data=0x1234; following cycle rf_we=0.
- issue_valid, issue_rd=7; then rs1_addr=7 -> hazard_stall=1. Then lsu response rd=7, data=0xDEAD -> rf_we one cycle later; hazard_stall stays 1 during that cycle, drops to 0 the cycle after.
- Same cycle: alu_valid rd=3 data=0x11 and lsu_valid rd=9 data=0x22 -> rf writes 3/0x11 then 9/0x22 on consecutive cycles; lsu_ready=0 exactly one cycle.
- ALU rd=0 data=0xFFFF -> rf_we stays 0. Issue with rd=0 -> no pending bit set; hazard_stall=0 for rs1=0.
- Pending rd=4, issue_valid rd=4 -> issue_stall=1, no state change. Assert rst_n low mid-sequence -> all outputs at reset values, pending rd=4 cleared.
- With WB_BYPASS_EN, repeat test 2 -> fwd_rs1_valid=1, fwd_rs1_data=0xDEAD, and hazard_stall=0 in the rf_we cycle.
